dma_ctrlr_mc: RTL and testbench

DMA_CTRLR_MC -- requirements
Module: dma_ctrlr_mc

---
 rtl/dma_ctrlr_mc_if.sv | 47 ++++
 rtl/dma_ctrlr_mc.sv | 137 +++++++++++++
 tb/tb_dma_ctrlr_mc.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dma_ctrlr_mc_if.sv
// Bundle of the CPU descriptor port, the status outputs and the data-mover
// engine start/done port of the DMA dispatch controller.
interface dma_ctrlr_mc_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int NCH        = 2,
  parameter int DEPTH      = 4
);
  localparam int CH_W  = $clog2(NCH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] cpu_src_addr;
  logic [ADDR_WIDTH-1:0] cpu_dest_addr;
  logic [ADDR_WIDTH-1:0] cpu_length;
  logic [CH_W-1:0]       cpu_ch;
  logic                  cpu_valid;
  logic                  cpu_ready;
  logic                  cpu_abort;
  logic                  err_clr;

  logic                  busy;
  logic [CNT_W-1:0]      fifo_level;
  logic [15:0]           done_count;
  logic                  err_zero_len;
  logic                  err_bad_ch;

  logic [ADDR_WIDTH-1:0] dm_src_addr;
  logic [ADDR_WIDTH-1:0] dm_dest_addr;
  logic [ADDR_WIDTH-1:0] dm_length;
  logic [NCH-1:0]        dm_start;
  logic [NCH-1:0]        dm_done;

  // Controller side
  modport slave (
    input  cpu_src_addr, cpu_dest_addr, cpu_length, cpu_ch, cpu_valid,
    input  cpu_abort, err_clr, dm_done,
    output cpu_ready, busy, fifo_level, done_count, err_zero_len, err_bad_ch,
    output dm_src_addr, dm_dest_addr, dm_length, dm_start
  );

  // CPU / engine-model side
  modport master (
    output cpu_src_addr, cpu_dest_addr, cpu_length, cpu_ch, cpu_valid,
    output cpu_abort, err_clr, dm_done,
    input  cpu_ready, busy, fifo_level, done_count, err_zero_len, err_bad_ch,
    input  dm_src_addr, dm_dest_addr, dm_length, dm_start
  );
endinterface

// File: rtl/dma_ctrlr_mc.sv
// DMA descriptor queue and in-order dispatcher for NCH data-mover engines.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | descriptor FIFO empty
// CHECK   | head descriptor valid, evaluated for dispatch/drop
// BLOCKED | head descriptor targets a busy engine (stalls the whole queue)
module dma_ctrlr_mc #(
  parameter int ADDR_WIDTH = 64,
  parameter int NCH        = 2,
  parameter int DEPTH      = 4
) (
  input logic           aclk,
  input logic           aresetn,
  dma_ctrlr_mc_if.slave bus
);
  localparam int CH_W   = $clog2(NCH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CH_PAD = 1 << CH_W;

  typedef enum logic [1:0] {IDLE, CHECK, BLOCKED} state_t;
  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] src_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] dst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] len_mem [DEPTH];
  logic [CH_W-1:0]       ch_mem  [DEPTH];

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic [NCH-1:0]        eng_busy, eng_busy_next, done_ok;
  logic [CH_PAD-1:0]     busy_pad, start_pad;
  logic [15:0]           done_inc;
  logic                  full, push, pop, active, dispatch, head_blocked;
  logic                  head_bad_ch, head_zero_len;

  logic [ADDR_WIDTH-1:0] head_src, head_dst, head_len;
  logic [CH_W-1:0]       head_ch;

  assign full          = (count == CNT_W'(DEPTH));
  assign bus.cpu_ready = !full && !bus.cpu_abort;
  assign push          = bus.cpu_valid && bus.cpu_ready;
  assign bus.fifo_level = count;

  assign head_src = src_mem[rd_ptr];
  assign head_dst = dst_mem[rd_ptr];
  assign head_len = len_mem[rd_ptr];
  assign head_ch  = ch_mem[rd_ptr];

  // Head decode: drop illegal/empty descriptors, dispatch to idle engines.
  // Engine busy bits are padded to a power of two so an out-of-range channel
  // still indexes a defined (zero) bit.
  always_comb begin
    busy_pad = '0;
    busy_pad[NCH-1:0] = eng_busy;
    head_bad_ch   = ({1'b0, head_ch} >= (CH_W + 1)'(NCH));
    head_zero_len = (head_len == '0);
    active        = (state != IDLE) && !bus.cpu_abort;
    pop           = active && (head_bad_ch || head_zero_len || !busy_pad[head_ch]);
    dispatch      = active && !head_bad_ch && !head_zero_len && !busy_pad[head_ch];
    head_blocked  = active && !pop;
    start_pad = '0;
    if (dispatch) start_pad[head_ch] = 1'b1;
    done_ok  = bus.dm_done & eng_busy;
    done_inc = '0;
    for (int i = 0; i < NCH; i++) done_inc = done_inc + 16'(done_ok[i]);
    eng_busy_next = (eng_busy & ~bus.dm_done) | start_pad[NCH-1:0];
    if (bus.cpu_abort) count_next = '0;
    else               count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Next-state: queue occupancy after this edge, and whether the head stalled.
  always_comb begin
    state_next = state;
    if (count_next == '0)  state_next = IDLE;
    else if (head_blocked) state_next = BLOCKED;
    else                   state_next = CHECK;
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  // Descriptor storage; contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (push) begin
      src_mem[wr_ptr] <= bus.cpu_src_addr;
      dst_mem[wr_ptr] <= bus.cpu_dest_addr;
      len_mem[wr_ptr] <= bus.cpu_length;
      ch_mem[wr_ptr]  <= bus.cpu_ch;
    end
  end

  // Queue pointers, engine tracking, dispatch outputs and status.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      eng_busy         <= '0;
      bus.dm_start     <= '0;
      bus.dm_src_addr  <= '0;
      bus.dm_dest_addr <= '0;
      bus.dm_length    <= '0;
      bus.done_count   <= '0;
      bus.err_zero_len <= 1'b0;
      bus.err_bad_ch   <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      if (bus.cpu_abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count        <= count_next;
      eng_busy     <= eng_busy_next;
      bus.dm_start <= start_pad[NCH-1:0];
      if (dispatch) begin
        bus.dm_src_addr  <= head_src;
        bus.dm_dest_addr <= head_dst;
        bus.dm_length    <= head_len;
      end
      bus.done_count <= bus.done_count + done_inc;
      // A new error wins over a simultaneous clear.
      if (pop && head_bad_ch)        bus.err_bad_ch <= 1'b1;
      else if (bus.err_clr)          bus.err_bad_ch <= 1'b0;
      if (pop && head_zero_len)      bus.err_zero_len <= 1'b1;
      else if (bus.err_clr)          bus.err_zero_len <= 1'b0;
      bus.busy <= (count_next != '0) || (|eng_busy_next);
    end
  end
endmodule

// File: tb/tb_dma_ctrlr_mc.sv
// Directed bench for dma_ctrlr_mc with three engines (so an out-of-range
// channel is encodable) and a four-entry descriptor queue.
module tb_dma_ctrlr_mc;
  localparam int ADDR_WIDTH = 64;
  localparam int NCH        = 3;
  localparam int DEPTH      = 4;

  logic aclk;
  logic aresetn;
  int   n_chk  = 0;
  int   n_pass = 0;

  dma_ctrlr_mc_if #(.ADDR_WIDTH(ADDR_WIDTH), .NCH(NCH), .DEPTH(DEPTH)) bus ();

  dma_ctrlr_mc #(.ADDR_WIDTH(ADDR_WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_desc(input logic [63:0] s, input logic [63:0] d,
                           input logic [63:0] l, input logic [1:0] c);
    bus.cpu_src_addr  = s;
    bus.cpu_dest_addr = d;
    bus.cpu_length    = l;
    bus.cpu_ch        = c;
    bus.cpu_valid     = 1'b1;
    tick();
    bus.cpu_valid     = 1'b0;
  endtask

  task automatic done_pulse(input logic [NCH-1:0] m);
    bus.dm_done = m;
    tick();
    bus.dm_done = '0;
  endtask

  initial begin
    aresetn           = 1'b0;
    bus.cpu_src_addr  = '0;
    bus.cpu_dest_addr = '0;
    bus.cpu_length    = '0;
    bus.cpu_ch        = '0;
    bus.cpu_valid     = 1'b0;
    bus.cpu_abort     = 1'b0;
    bus.err_clr       = 1'b0;
    bus.dm_done       = '0;
    tick();
    tick();
    aresetn = 1'b1;

    // reset state
    chk_val("rst_level",    64'(bus.fifo_level), 0);
    chk_val("rst_busy",     64'(bus.busy), 0);
    chk_val("rst_start",    64'(bus.dm_start), 0);
    chk_val("rst_done_cnt", 64'(bus.done_count), 0);
    chk_val("rst_err_zero", 64'(bus.err_zero_len), 0);
    chk_val("rst_err_bad",  64'(bus.err_bad_ch), 0);
    chk_val("rst_ready",    64'(bus.cpu_ready), 1);

    // single transfer, one-cycle push-to-dispatch
    push_desc(64'h1000, 64'h2000, 64'h40, 2'd0);
    chk_val("t1_level_push", 64'(bus.fifo_level), 1);
    chk_val("t1_no_start",   64'(bus.dm_start), 0);
    tick();
    chk_val("t1_start", 64'(bus.dm_start), 64'h1);
    chk_val("t1_src",   bus.dm_src_addr, 64'h1000);
    chk_val("t1_dst",   bus.dm_dest_addr, 64'h2000);
    chk_val("t1_len",   bus.dm_length, 64'h40);
    chk_val("t1_level", 64'(bus.fifo_level), 0);
    chk_val("t1_busy",  64'(bus.busy), 1);
    tick();
    chk_val("t1_start_pulse", 64'(bus.dm_start), 0);
    chk_val("t1_src_hold",    bus.dm_src_addr, 64'h1000);
    done_pulse(3'b001);
    chk_val("t1_done_cnt", 64'(bus.done_count), 1);
    chk_val("t1_idle",     64'(bus.busy), 0);

    // head blocking
    push_desc(64'h100, 64'h1100, 64'h10, 2'd0);
    push_desc(64'h200, 64'h1200, 64'h10, 2'd0);
    chk_val("t2_a_start",     64'(bus.dm_start), 64'h1);
    chk_val("t2_a_src",       bus.dm_src_addr, 64'h100);
    chk_val("t2_level_pushpop", 64'(bus.fifo_level), 1);
    push_desc(64'h300, 64'h1300, 64'h10, 2'd1);
    tick();
    chk_val("t2_level_blk", 64'(bus.fifo_level), 2);
    chk_val("t2_blk_start", 64'(bus.dm_start), 0);
    tick();
    tick();
    chk_val("t2_ch1_waits", 64'(bus.dm_start), 0);
    chk_val("t2_src_hold",  bus.dm_src_addr, 64'h100);
    done_pulse(3'b001);
    chk_val("t2_done_cnt",     64'(bus.done_count), 2);
    chk_val("t2_done_no_disp", 64'(bus.dm_start), 0);
    chk_val("t2_level_done",   64'(bus.fifo_level), 2);
    tick();
    chk_val("t2_b_start", 64'(bus.dm_start), 64'h1);
    chk_val("t2_b_src",   bus.dm_src_addr, 64'h200);
    tick();
    chk_val("t2_c_start", 64'(bus.dm_start), 64'h2);
    chk_val("t2_c_src",   bus.dm_src_addr, 64'h300);
    chk_val("t2_level_0", 64'(bus.fifo_level), 0);
    done_pulse(3'b011);
    chk_val("t2_done_both", 64'(bus.done_count), 4);
    chk_val("t2_idle",      64'(bus.busy), 0);
    done_pulse(3'b100);
    chk_val("t2_stray_done", 64'(bus.done_count), 4);

    // full queue and pointer wrap
    push_desc(64'hA0, 64'hB0, 64'h1, 2'd0);
    tick();
    chk_val("t3_w_start", 64'(bus.dm_start), 64'h1);
    for (int i = 0; i < 4; i++) push_desc(64'h10 + 64'(i), 64'h0, 64'h1, 2'd0);
    chk_val("t3_full_level", 64'(bus.fifo_level), 4);
    bus.cpu_src_addr = 64'h99;
    bus.cpu_valid    = 1'b1;
    #1;
    chk_val("t3_full_ready", 64'(bus.cpu_ready), 0);
    tick();
    bus.cpu_valid = 1'b0;
    chk_val("t3_full_hold", 64'(bus.fifo_level), 4);
    for (int i = 0; i < 4; i++) begin
      done_pulse(3'b001);
      tick();
      chk_val("t3_q_start", 64'(bus.dm_start), 64'h1);
      chk_val("t3_q_src",   bus.dm_src_addr, 64'h10 + 64'(i));
    end
    for (int i = 0; i < 4; i++) push_desc(64'h20 + 64'(i), 64'h0, 64'h1, 2'd0);
    chk_val("t3_refill_level", 64'(bus.fifo_level), 4);
    for (int i = 0; i < 4; i++) begin
      done_pulse(3'b001);
      tick();
      chk_val("t3_r_start", 64'(bus.dm_start), 64'h1);
      chk_val("t3_r_src",   bus.dm_src_addr, 64'h20 + 64'(i));
    end
    done_pulse(3'b001);
    chk_val("t3_done_cnt", 64'(bus.done_count), 13);
    chk_val("t3_idle",     64'(bus.busy), 0);

    // error drops and sticky flags
    push_desc(64'h400, 64'h410, 64'h0, 2'd1);
    chk_val("t4_zl_level", 64'(bus.fifo_level), 1);
    tick();
    chk_val("t4_zl_start", 64'(bus.dm_start), 0);
    chk_val("t4_zl_err",   64'(bus.err_zero_len), 1);
    chk_val("t4_zl_drop",  64'(bus.fifo_level), 0);
    push_desc(64'h420, 64'h430, 64'h8, 2'd3);
    tick();
    chk_val("t4_bad_start", 64'(bus.dm_start), 0);
    chk_val("t4_bad_err",   64'(bus.err_bad_ch), 1);
    chk_val("t4_bad_drop",  64'(bus.fifo_level), 0);
    chk_val("t4_bad_src",   bus.dm_src_addr, 64'h23);
    push_desc(64'h440, 64'h450, 64'h0, 2'd0);
    bus.err_clr = 1'b1;
    tick();
    chk_val("t4_set_wins", 64'(bus.err_zero_len), 1);
    chk_val("t4_bad_clr",  64'(bus.err_bad_ch), 0);
    tick();
    bus.err_clr = 1'b0;
    chk_val("t4_zl_clr",   64'(bus.err_zero_len), 0);
    chk_val("t4_done_cnt", 64'(bus.done_count), 13);

    // abort with a running engine
    push_desc(64'h500, 64'h510, 64'h20, 2'd1);
    tick();
    chk_val("t5_d_start", 64'(bus.dm_start), 64'h2);
    for (int i = 0; i < 3; i++) push_desc(64'h520 + 64'(i), 64'h0, 64'h4, 2'd1);
    chk_val("t5_queued", 64'(bus.fifo_level), 3);
    bus.cpu_abort = 1'b1;
    #1;
    chk_val("t5_abort_ready", 64'(bus.cpu_ready), 0);
    tick();
    bus.cpu_abort = 1'b0;
    chk_val("t5_flushed",  64'(bus.fifo_level), 0);
    chk_val("t5_no_start", 64'(bus.dm_start), 0);
    chk_val("t5_busy_eng", 64'(bus.busy), 1);
    done_pulse(3'b010);
    chk_val("t5_done_cnt", 64'(bus.done_count), 14);
    chk_val("t5_idle",     64'(bus.busy), 0);
    push_desc(64'h600, 64'h610, 64'h4, 2'd2);
    bus.cpu_abort = 1'b1;
    tick();
    bus.cpu_abort = 1'b0;
    chk_val("t5_abort_supp",  64'(bus.dm_start), 0);
    chk_val("t5_abort_level", 64'(bus.fifo_level), 0);
    chk_val("t5_abort_idle",  64'(bus.busy), 0);
    tick();
    chk_val("t5_abort_after", 64'(bus.dm_start), 0);

    // reset mid-transfer
    push_desc(64'h700, 64'h1700, 64'h10, 2'd0);
    tick();
    chk_val("t6_start", 64'(bus.dm_start), 64'h1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk_val("t6_rst_start", 64'(bus.dm_start), 0);
    chk_val("t6_rst_src",   bus.dm_src_addr, 0);
    chk_val("t6_rst_dst",   bus.dm_dest_addr, 0);
    chk_val("t6_rst_len",   bus.dm_length, 0);
    chk_val("t6_rst_cnt",   64'(bus.done_count), 0);
    chk_val("t6_rst_busy",  64'(bus.busy), 0);
    chk_val("t6_rst_level", 64'(bus.fifo_level), 0);
    done_pulse(3'b001);
    chk_val("t6_stray_cnt",  64'(bus.done_count), 0);
    chk_val("t6_stray_busy", 64'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
